// File: rtl/usb_fs_pkg.sv
// Shared line-state encoding, receiver FSM states and USB framing constants.
// Line states are encoded {D+, D-} so a synchronised pair casts straight to line_t.
package usb_fs_pkg;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } line_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ABORT
    } rx_state_t;

    // SYNC is K J K J K J K K; bit i set means the i-th sampled symbol must be K.
    localparam logic [7:0] SYNC_PATTERN = 8'b1101_0101;
    localparam logic [2:0] STUFF_LIMIT  = 3'd6;

    function automatic line_t decode_line(input logic p, input logic m);
        return line_t'({p, m});
    endfunction

endpackage

// File: rtl/usb_fs_rx_if.sv
// Bus-side signals of the FS receiver: raw D+/D- in, byte/EOP/error strobes out.
// The master modport is the line driver and byte consumer; slave is the receiver.
interface usb_fs_rx_if;
    logic       linep;
    logic       linem;
    logic       rx_active;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_eop;
    logic       rx_error;

    modport master (
        output linep, linem,
        input  rx_active, rx_data, rx_valid, rx_eop, rx_error
    );

    modport slave (
        input  linep, linem,
        output rx_active, rx_data, rx_valid, rx_eop, rx_error
    );
endinterface

// File: rtl/usb_fs_dpll.sv
// Line synchroniser + bit-clock recovery: phase counter re-aligns on every line-state change.
// Latency: 2 sync cycles, strobe CLK_PER_BIT/2 cycles into each bit; no backpressure.
module usb_fs_dpll
    import usb_fs_pkg::*;
#(
    parameter int CLK_PER_BIT = 4
) (
    input  logic  clk,
    input  logic  nreset,
    input  logic  linep_i,
    input  logic  linem_i,
    output logic  smp_vld_o,
    output line_t smp_ls_o
);
    localparam int            CW        = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] PH_SAMPLE = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] PH_LAST   = CW'(CLK_PER_BIT - 1);

    logic [1:0]    p_q;
    logic [1:0]    m_q;
    line_t         line_q;
    line_t         line_now;
    logic [CW-1:0] ph_q;
    logic [CW-1:0] ph_d;

    assign line_now = decode_line(p_q[1], m_q[1]);

    always_comb begin
        ph_d = ph_q + CW'(1);
        if (line_now != line_q || ph_q == PH_LAST) begin
            ph_d = '0;
        end
    end

    // Synchronisers come out of reset showing an idle J so no spurious edge is seen.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            p_q    <= 2'b11;
            m_q    <= 2'b00;
            line_q <= LS_J;
            ph_q   <= '0;
        end else begin
            p_q    <= {p_q[0], linep_i};
            m_q    <= {m_q[0], linem_i};
            line_q <= line_now;
            ph_q   <= ph_d;
        end
    end

    assign smp_vld_o = (ph_q == PH_SAMPLE);
    assign smp_ls_o  = line_q;

endmodule

// File: rtl/usb_fs_rx.sv
// USB FS receiver: SYNC detect, NRZI decode, bit unstuffing, byte assembly, EOP/error strobes.
// Strobes appear one cycle after the deciding sample strobe; no backpressure.
module usb_fs_rx
    import usb_fs_pkg::*;
#(
    parameter int CLK_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        nreset,
    usb_fs_rx_if.slave  bus
);
    logic      smp_vld;
    line_t     smp_ls;

    rx_state_t state_q, state_d;
    line_t     prev_q, prev_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] ones_q, ones_d;
    logic [2:0] sync_cnt_q, sync_cnt_d;
    logic      j_cnt_q, j_cnt_d;
    logic      valid_q, valid_d;
    logic      eop_q, eop_d;
    logic      error_q, error_d;
    logic      nrzi_bit;

    usb_fs_dpll #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_dpll (
        .clk       (clk),
        .nreset    (nreset),
        .linep_i   (bus.linep),
        .linem_i   (bus.linem),
        .smp_vld_o (smp_vld),
        .smp_ls_o  (smp_ls)
    );

    assign nrzi_bit = (smp_ls == prev_q);

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        shift_d    = shift_q;
        data_d     = data_q;
        bit_cnt_d  = bit_cnt_q;
        ones_d     = ones_q;
        sync_cnt_d = sync_cnt_q;
        j_cnt_d    = j_cnt_q;
        valid_d    = 1'b0;
        eop_d      = 1'b0;
        error_d    = 1'b0;
        if (smp_vld) begin
            prev_d = smp_ls;
            case (state_q)
                ST_IDLE: begin
                    if (prev_q == LS_J && smp_ls == LS_K) begin
                        state_d    = ST_SYNC;
                        sync_cnt_d = 3'd1;
                    end
                end
                ST_SYNC: begin
                    if (smp_ls != (SYNC_PATTERN[sync_cnt_q] ? LS_K : LS_J)) begin
                        state_d = ST_IDLE;
                    end else if (sync_cnt_q == 3'd7) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        ones_d    = '0;
                    end else begin
                        sync_cnt_d = sync_cnt_q + 3'd1;
                    end
                end
                ST_DATA: begin
                    if (smp_ls == LS_SE0) begin
                        state_d = ST_EOP;
                    end else if (smp_ls == LS_SE1) begin
                        error_d = 1'b1;
                        state_d = ST_ABORT;
                    end else if (ones_q == STUFF_LIMIT) begin
                        // Stuff slot: a 0 is dropped, a 1 means the sender broke the rule.
                        if (nrzi_bit) begin
                            error_d = 1'b1;
                            state_d = ST_ABORT;
                        end else begin
                            ones_d = '0;
                        end
                    end else begin
                        ones_d    = nrzi_bit ? ones_q + 3'd1 : 3'd0;
                        shift_d   = {nrzi_bit, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_d  = {nrzi_bit, shift_q[7:1]};
                            valid_d = 1'b1;
                        end
                    end
                end
                ST_EOP: begin
                    if (smp_ls == LS_J) begin
                        eop_d   = 1'b1;
                        error_d = (bit_cnt_q != 3'd0);
                        state_d = ST_IDLE;
                    end else if (smp_ls != LS_SE0) begin
                        error_d = 1'b1;
                        state_d = ST_ABORT;
                    end
                end
                ST_ABORT: begin
                    if (smp_ls == LS_J) begin
                        j_cnt_d = 1'b1;
                        if (j_cnt_q) begin
                            j_cnt_d = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        j_cnt_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_IDLE;
            prev_q     <= LS_J;
            shift_q    <= '0;
            data_q     <= '0;
            bit_cnt_q  <= '0;
            ones_q     <= '0;
            sync_cnt_q <= '0;
            j_cnt_q    <= 1'b0;
            valid_q    <= 1'b0;
            eop_q      <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_q     <= ones_d;
            sync_cnt_q <= sync_cnt_d;
            j_cnt_q    <= j_cnt_d;
            valid_q    <= valid_d;
            eop_q      <= eop_d;
            error_q    <= error_d;
        end
    end

    assign bus.rx_active = (state_q == ST_DATA) || (state_q == ST_EOP);
    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.rx_eop    = eop_q;
    assign bus.rx_error  = error_q;

endmodule
